// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte requesters.
// Each grant latches the byte, pulses tx_en until tx_busy rises, then acks the requester when the frame ends.
module uart_tx_arb #(
  parameter int NREQ     = 4,
  parameter int START_TO = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    tx_en,
  output logic [7:0]              tx_dfifo,
  input  logic                    tx_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(START_TO + 1);

  typedef enum logic [1:0] {IDLE, GNT, XFER, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [IDW-1:0]  gnt_id_nxt;
  logic            busy_nxt, timeout_err_nxt, tx_en_nxt;
  logic [7:0]      tx_dfifo_nxt;
  logic            win_vld;
  logic [IDW-1:0]  win_id;

  // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(NREQ - 1)) return '0;
    return id + IDW'(1);
  endfunction

  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    cnt_nxt         = cnt;
    ack_nxt         = '0;
    gnt_id_nxt      = gnt_id;
    timeout_err_nxt = 1'b0;
    tx_en_nxt       = tx_en;
    tx_dfifo_nxt    = tx_dfifo;
    case (state)
      IDLE: begin
        if (!tx_busy && win_vld) begin
          gnt_id_nxt   = win_id;
          tx_dfifo_nxt = req_data[8*int'(win_id) +: 8];
          tx_en_nxt    = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = GNT;
        end
      end
      GNT: begin
        if (tx_busy) begin
          tx_en_nxt = 1'b0;
          state_nxt = XFER;
        end else if (cnt == CW'(START_TO - 1)) begin
          tx_en_nxt       = 1'b0;
          timeout_err_nxt = 1'b1;
          ptr_nxt         = next_id(gnt_id);
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      XFER: begin
        if (!tx_busy) begin
          ack_nxt[gnt_id] = 1'b1;
          state_nxt       = DONE;
        end
      end
      DONE: begin
        ptr_nxt   = next_id(gnt_id);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      ack         <= '0;
      gnt_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      tx_en       <= 1'b0;
      tx_dfifo    <= 8'h00;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      ack         <= ack_nxt;
      gnt_id      <= gnt_id_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
      tx_en       <= tx_en_nxt;
      tx_dfifo    <= tx_dfifo_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural stand-in for the UART transmitter.
// The stand-in captures tx_dfifo/gnt_id when it sees tx_en, then raises tx_busy for a frame.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        timeout_err;
  logic        tx_en;
  logic [7:0]  tx_dfifo;
  logic        tx_busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic       model_on = 1'b1;
  logic [7:0] rx_q[$];
  logic [1:0] gid_q[$];
  int en_cycles = 0;
  int to_cnt    = 0;
  int ack_cnt   = 0;

  uart_tx_arb #(.NREQ(4), .START_TO(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err),
    .tx_en(tx_en), .tx_dfifo(tx_dfifo), .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter stand-in: 2-cycle start latency, 20-cycle frame.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_on && tx_en) begin
        rx_q.push_back(tx_dfifo);
        gid_q.push_back(gnt_id);
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_en) en_cycles++;
      if (timeout_err) to_cnt++;
      if (ack != 4'b0) ack_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, output logic [3:0] a);
    int n;
    n = 0;
    while (ack == 4'b0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 32'(ack != 4'b0), 32'd1);
    a = ack;
  endtask

  task automatic wait_txbusy(input logic lvl);
    int n;
    n = 0;
    while (tx_busy !== lvl && n < 300) begin
      step();
      n++;
    end
    chk("tx_busy_level", 32'(tx_busy), 32'(lvl));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [3:0] a;
    int base, e0, t0, a0, n, bad;
    rst      = 1'b1;
    req      = 4'b0;
    req_data = 32'h0;
    step();
    step();
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_dfifo", 32'(tx_dfifo), 32'h00);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step();

    // Single request from requester 1
    t0 = to_cnt;
    base = rx_q.size();
    req_data[15:8] = 8'h5C;
    req = 4'b0010;
    wait_ack("single", a);
    chk("single_ack", 32'(a), 32'b0010);
    req = 4'b0;
    step();
    chk("single_ack_one_cycle", 32'(ack), 32'd0);
    chk("single_frames", 32'(rx_q.size() - base), 32'd1);
    chk("single_byte", 32'(rx_q[rx_q.size()-1]), 32'h5C);
    chk("single_no_timeout", 32'(to_cnt - t0), 32'd0);

    // All four at once from ptr=0
    pulse_rst();
    base = rx_q.size();
    req_data = 32'hEFBEADDE;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack("all4", a);
      chk("all4_ack_order", 32'(a), 32'(4'b0001 << k));
      req[k] = 1'b0;
      step();
    end
    chk("all4_frames", 32'(rx_q.size() - base), 32'd4);
    chk("all4_byte0", 32'(rx_q[base]), 32'hDE);
    chk("all4_byte1", 32'(rx_q[base+1]), 32'hAD);
    chk("all4_byte2", 32'(rx_q[base+2]), 32'hBE);
    chk("all4_byte3", 32'(rx_q[base+3]), 32'hEF);

    // Fairness: req[0] held, req[2] joins during the first frame
    base = rx_q.size();
    req_data = 32'h00220011;
    req = 4'b0001;
    wait_txbusy(1'b1);
    req[2] = 1'b1;
    wait_ack("fair1", a);
    chk("fair1_ack", 32'(a), 32'b0001);
    step();
    wait_ack("fair2", a);
    chk("fair2_ack", 32'(a), 32'b0100);
    req[2] = 1'b0;
    step();
    wait_ack("fair3", a);
    chk("fair3_ack", 32'(a), 32'b0001);
    req[0] = 1'b0;
    step();
    chk("fair_gid0", 32'(gid_q[base]), 32'd0);
    chk("fair_gid1", 32'(gid_q[base+1]), 32'd2);
    chk("fair_gid2", 32'(gid_q[base+2]), 32'd0);

    // Start timeout: transmitter never goes busy
    model_on = 1'b0;
    a0 = ack_cnt;
    t0 = to_cnt;
    e0 = en_cycles;
    req = 4'b1000;
    n = 0;
    while (to_cnt == t0 && n < 100) begin step(); n++; end
    chk("to1_pulse", 32'(to_cnt - t0), 32'd1);
    chk("to1_en_cycles", 32'(en_cycles - e0), 32'd16);
    e0 = en_cycles;
    n = 0;
    while (!tx_en && n < 10) begin step(); n++; end
    chk("to2_gnt_id", 32'(gnt_id), 32'd3);
    n = 0;
    while (to_cnt == t0 + 1 && n < 100) begin step(); n++; end
    req = 4'b0;
    chk("to2_pulse", 32'(to_cnt - t0), 32'd2);
    chk("to2_en_cycles", 32'(en_cycles - e0), 32'd16);
    repeat (3) step();
    chk("to_single_pulses", 32'(to_cnt - t0), 32'd2);
    chk("to_no_ack", 32'(ack_cnt - a0), 32'd0);
    model_on = 1'b1;

    // Data changes after grant are not seen by the frame
    req_data = 32'h0000005B;
    req = 4'b0001;
    n = 0;
    while (!tx_en && n < 10) begin step(); n++; end
    step();
    req_data[7:0] = 8'h00;
    step();
    chk("latch_tx_dfifo", 32'(tx_dfifo), 32'h5B);
    wait_ack("latch", a);
    req = 4'b0;
    step();
    chk("latch_rx_byte", 32'(rx_q[rx_q.size()-1]), 32'h5B);

    // Reset in the middle of a frame
    req_data = 32'h00773C00;
    req = 4'b0010;
    wait_txbusy(1'b1);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("rstx_tx_en", 32'(tx_en), 32'd0);
    chk("rstx_busy", 32'(busy), 32'd0);
    chk("rstx_ack", 32'(ack), 32'd0);
    req = 4'b0;
    step();
    step();
    rst = 1'b0;
    req = 4'b0100;
    bad = 0;
    n = 0;
    while (tx_busy && n < 300) begin
      if (busy) bad++;
      step();
      n++;
    end
    chk("rstx_no_gnt_while_txbusy", 32'(bad), 32'd0);
    wait_ack("rstx", a);
    chk("rstx_ack_after", 32'(a), 32'b0100);
    req = 4'b0;
    step();
    chk("rstx_rx_byte", 32'(rx_q[rx_q.size()-1]), 32'h77);
    chk("rstx_gid", 32'(gid_q[gid_q.size()-1]), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
